// File: rtl/demux1to4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux1to4_stream
// Description : Registered 1-to-4 stream demultiplexer with per-slot
//               one-entry buffers and an accepted-transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1to4_stream #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    fn_sel,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  output logic [N-1:0]  c,
  output logic [N-1:0]  d,
  output logic          a_valid,
  output logic          b_valid,
  output logic          c_valid,
  output logic          d_valid,
  input  logic          a_ready,
  input  logic          b_ready,
  input  logic          c_ready,
  input  logic          d_ready,
  output logic [CW-1:0] xfer_cnt
);

  logic [N-1:0]  data_q [4];
  logic [N-1:0]  data_d [4];
  logic [3:0]    valid_q;
  logic [3:0]    valid_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    w_ready;
  logic          w_accept;

  assign w_ready = {d_ready, c_ready, b_ready, a_ready};

  // A slot can take a new word if empty or if it is draining on this same edge.
  assign in_ready = !rst && (!valid_q[fn_sel] || w_ready[fn_sel]);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q + CW'(w_accept);
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i] && w_ready[i]) begin
        valid_d[i] = 1'b0;
      end
      if (w_accept && (fn_sel == 2'(i))) begin
        data_d[i]  = in;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign a        = data_q[0];
  assign b        = data_q[1];
  assign c        = data_q[2];
  assign d        = data_q[3];
  assign a_valid  = valid_q[0];
  assign b_valid  = valid_q[1];
  assign c_valid  = valid_q[2];
  assign d_valid  = valid_q[3];
  assign xfer_cnt = cnt_q;

endmodule
`default_nettype wire
